// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // True for the opcodes the ALU actually implements.
  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational add/subtract ALU; unsupported opcodes give zero plus an error flag.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  // Wrap-around arithmetic: carry and borrow fall off the top bit.
  always_comb begin
    result_o = '0;
    err_o    = !op_supported(op_i);
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter time-sharing one ALU between two requesters, one op in flight.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  state_e           state_q;
  req_id_e          owner_q;
  req_id_e          last_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_err;
  logic             accept;
  req_id_e          grant_id;
  logic             owner_rsp_ready;

  // Grant goes to the lone valid requester, or on a tie to the one not served last.
  always_comb begin
    req0_ready      = (state_q == ST_IDLE) && req0_valid && (!req1_valid || (last_q == REQ1));
    req1_ready      = (state_q == ST_IDLE) && req1_valid && (!req0_valid || (last_q == REQ0));
    accept          = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    grant_id        = req1_ready ? REQ1 : REQ0;
    owner_rsp_ready = (owner_q == REQ0) ? rsp0_ready : rsp1_ready;
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  // Main FSM: latch the winner's operation, compute for one cycle, hold result until owner takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ0;
      last_q       <= REQ1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      result_q     <= '0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= (grant_id == REQ1) ? req1_a  : req0_a;
            b_q     <= (grant_id == REQ1) ? req1_b  : req0_b;
            op_q    <= (grant_id == REQ1) ? req1_op : req0_op;
            owner_q <= grant_id;
            last_q  <= grant_id;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q     <= alu_result;
          err_q        <= alu_err;
          rsp0_valid_q <= (owner_q == REQ0);
          rsp1_valid_q <= (owner_q == REQ1);
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 3'b000;
    req1_a = '0; req1_b = '0; req1_op = 3'b000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b%b exp=00", rsp0_valid, rsp1_valid); end
    checks++; if (rsp_result !== 16'h0000) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0000", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", rsp_err); end
    do_reset();
  endtask

  task automatic test_req0_add;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0003; req0_op = 3'b000;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL add_ready got=%b%b exp=10", req0_ready, req1_ready); end
    tick(); req0_valid = 1'b0;
    checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL add_exec busy/valid/ready got=%b%b%b exp=100", busy, rsp0_valid, req0_ready); end
    tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_rsp_valid got=%b%b exp=10", rsp0_valid, rsp1_valid); end
    checks++; if (rsp_result !== 16'h0008 || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL add_result got=%h/%b exp=0008/0", rsp_result, rsp_err); end
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_done busy/valid got=%b%b exp=00", busy, rsp0_valid); end
  endtask

  task automatic test_req1_sub;
    do_reset();
    req1_valid = 1'b1; req1_a = 16'h0000; req1_b = 16'h0001; req1_op = 3'b001;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL sub_ready got=%b%b exp=01", req0_ready, req1_ready); end
    tick(); req1_valid = 1'b0;
    tick();
    checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin failures++; $display("[TB] FAIL sub_rsp_valid got=%b%b exp=01", rsp0_valid, rsp1_valid); end
    checks++; if (rsp_result !== 16'hFFFF || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL sub_result got=%h/%b exp=ffff/0", rsp_result, rsp_err); end
    rsp1_ready = 1'b1; tick(); rsp1_ready = 1'b0;
    checks++; if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("[TB] FAIL sub_done busy/valid got=%b%b exp=00", busy, rsp1_valid); end
  endtask

  task automatic test_alternate;
    logic [WIDTH-1:0] exp_res;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h000A; req0_b = 16'h0001; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 16'h000A; req1_b = 16'h0001; req1_op = 3'b001;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_res = (i % 2 == 0) ? 16'h000B : 16'h0009;
      checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin failures++; $display("[TB] FAIL rr_grant%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
      tick(); tick();
      checks++; if (rsp0_valid !== (i % 2 == 0) || rsp1_valid !== (i % 2 == 1)) begin failures++; $display("[TB] FAIL rr_route%0d got=%b%b exp=%b%b", i, rsp0_valid, rsp1_valid, (i % 2 == 0), (i % 2 == 1)); end
      checks++; if (rsp_result !== exp_res) begin failures++; $display("[TB] FAIL rr_result%0d got=%h exp=%h", i, rsp_result, exp_res); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_hold_and_wait;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0023; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 16'h0007; req1_b = 16'h0002; req1_op = 3'b001;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
    tick(); req0_valid = 1'b0;
    tick();
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 16'h0123 || busy !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold_cycle%0d valid/result/busy/ready1 got=%b/%h/%b/%b exp=1/0123/1/0", i, rsp0_valid, rsp_result, busy, req1_ready); end
      tick();
    end
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    checks++; if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL hold_release valid0/ready1 got=%b%b exp=01", rsp0_valid, req1_ready); end
    tick(); req1_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_req1_accept busy got=%b exp=1", busy); end
    tick();
    checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 16'h0005) begin failures++; $display("[TB] FAIL hold_req1_rsp valid/result got=%b%b/%h exp=01/0005", rsp0_valid, rsp1_valid, rsp_result); end
    tick(); rsp1_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_end busy got=%b exp=0", busy); end
  endtask

  task automatic test_err_and_wrap;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_op = 3'b101;
    tick(); req0_valid = 1'b0;
    tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 16'h0000 || rsp_err !== 1'b1) begin failures++; $display("[TB] FAIL err_op valid/result/err got=%b/%h/%b exp=1/0000/1", rsp0_valid, rsp_result, rsp_err); end
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_op = 3'b000;
    tick(); req0_valid = 1'b0;
    tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 16'h0000 || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL wrap_add valid/result/err got=%b/%h/%b exp=1/0000/0", rsp0_valid, rsp_result, rsp_err); end
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0003; req0_op = 3'b000;
    tick(); req0_valid = 1'b0;
    tick();
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0009; req0_b = 16'h0001; req0_op = 3'b000;
    tick(); req0_valid = 1'b0;
    checks++; if (busy !== 1'b1 || rsp_result !== 16'h0008) begin failures++; $display("[TB] FAIL mid_pre busy/result got=%b/%h exp=1/0008", busy, rsp_result); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_result !== 16'h0000 || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset busy/valid/result/err got=%b/%b%b/%h/%b exp=0/00/0000/0", busy, rsp0_valid, rsp1_valid, rsp_result, rsp_err); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_rsp%0d valid/busy got=%b/%b exp=0/0", i, rsp0_valid, busy); end
    end
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002; req1_op = 3'b000;
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_fresh_ready got=%b exp=1", req1_ready); end
    tick(); req1_valid = 1'b0;
    tick();
    checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 16'h0004 || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_fresh_rsp valid/result/err got=%b/%h/%b exp=1/0004/0", rsp1_valid, rsp_result, rsp_err); end
    rsp1_ready = 1'b1; tick(); rsp1_ready = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    do_reset();
    test_reset();
    test_req0_add();
    test_req1_sub();
    test_alternate();
    test_hold_and_wait();
    test_err_and_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
